keypad_scanner: RTL

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner_if.sv | 25 ++
 rtl/keypad_scanner.sv | 127 ++++++++++++
 2 files changed

// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad pins and decoded key outputs of the scanner
// The slave modport is the scanner; the master side drives rows and scan_stop.
interface keypad_scanner_if;
  logic [3:0] row;
  logic       scan_stop;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_detected;

  modport slave (
    input  row,
    input  scan_stop,
    output col,
    output key_code,
    output key_detected
  );

  modport master (
    output row,
    output scan_stop,
    input  col,
    input  key_code,
    input  key_detected
  );
endinterface

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad column scanner with single-key lock
// Scans columns one-hot active-low, latches the first key seen and tracks that row for the debouncer.
module keypad_scanner #(
  parameter int DWELL  = 3000,
  parameter int SETTLE = 4
) (
  input  logic              clk,
  input  logic              rst,
  keypad_scanner_if.slave   kp
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic {
    S_SCAN = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t        r_state;
  logic [3:0]    r_sync1;
  logic [3:0]    r_rs;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_col_idx;
  logic [3:0]    r_col;
  logic [3:0]    r_key_code;
  logic          r_key_detected;
  logic [1:0]    r_lrow;

  logic [1:0]    w_low_row;
  logic [3:0]    w_key;
  logic [1:0]    w_next_idx;
  logic [3:0]    w_next_col;
  logic          w_settled;
  logic          w_any_low;

  // Lowest-numbered low row wins when several are pressed together
  always_comb begin
    w_low_row = 2'd0;
    casez (r_rs)
      4'b???0: w_low_row = 2'd0;
      4'b??01: w_low_row = 2'd1;
      4'b?011: w_low_row = 2'd2;
      4'b0111: w_low_row = 2'd3;
      default: w_low_row = 2'd0;
    endcase
  end

  always_comb begin
    w_key = 4'h0;
    case ({w_low_row, r_col_idx})
      4'b00_00: w_key = 4'h1;
      4'b00_01: w_key = 4'h2;
      4'b00_10: w_key = 4'h3;
      4'b00_11: w_key = 4'hA;
      4'b01_00: w_key = 4'h4;
      4'b01_01: w_key = 4'h5;
      4'b01_10: w_key = 4'h6;
      4'b01_11: w_key = 4'hB;
      4'b10_00: w_key = 4'h7;
      4'b10_01: w_key = 4'h8;
      4'b10_10: w_key = 4'h9;
      4'b10_11: w_key = 4'hC;
      4'b11_00: w_key = 4'hE;
      4'b11_01: w_key = 4'h0;
      4'b11_10: w_key = 4'hF;
      4'b11_11: w_key = 4'hD;
      default:  w_key = 4'h0;
    endcase
  end

  assign w_next_idx = r_col_idx + 2'd1;
  assign w_next_col = ~(4'b0001 << w_next_idx);
  assign w_settled  = (r_cnt >= CW'(SETTLE));
  assign w_any_low  = (r_rs != 4'b1111);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1        <= 4'b1111;
      r_rs           <= 4'b1111;
      r_state        <= S_SCAN;
      r_cnt          <= '0;
      r_col_idx      <= 2'd0;
      r_col          <= 4'b1110;
      r_key_code     <= 4'h0;
      r_key_detected <= 1'b0;
      r_lrow         <= 2'd0;
    end else begin
      r_sync1 <= kp.row;
      r_rs    <= r_sync1;
      case (r_state)
        S_SCAN: begin
          if (w_settled && w_any_low) begin
            r_state        <= S_HOLD;
            r_lrow         <= w_low_row;
            r_key_code     <= w_key;
            r_key_detected <= 1'b1;
          end else if (!kp.scan_stop) begin
            if (r_cnt == CW'(DWELL - 1)) begin
              r_cnt     <= '0;
              r_col_idx <= w_next_idx;
              r_col     <= w_next_col;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_HOLD: begin
          // Only the latched row is followed, so its bounce reaches the debouncer
          r_key_detected <= ~r_rs[r_lrow];
          if (!w_any_low && !kp.scan_stop) begin
            r_state        <= S_SCAN;
            r_cnt          <= '0;
            r_col_idx      <= w_next_idx;
            r_col          <= w_next_col;
            r_key_detected <= 1'b0;
          end
        end
        default: r_state <= S_SCAN;
      endcase
    end
  end

  assign kp.col          = r_col;
  assign kp.key_code     = r_key_code;
  assign kp.key_detected = r_key_detected;

endmodule
